multi_phase_traffic_ctrl: RTL and testbench

//  Next-generation intersection controller: generalises the 2-way NS/EW signal FSM to NUM_PHASES approaches.

---
 rtl/multi_phase_traffic_ctrl_if.sv | 26 ++
 rtl/multi_phase_traffic_ctrl.sv | 119 +++++++++++
 tb/tb_multi_phase_traffic_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_phase_traffic_ctrl_if.sv
// Detector-to-lamp bundle for the multi-phase controller: requests and pre-emption in, lamps and status out.
// No flow control: inputs are level-sampled every cycle, outputs are registered in the controller.
interface multi_phase_traffic_ctrl_if #(
  parameter int NUM_PHASES = 4
);
  localparam int PH_W = $clog2(NUM_PHASES);

  logic [NUM_PHASES-1:0] req;
  logic                  emerg;
  logic [PH_W-1:0]       emerg_phase;
  logic [NUM_PHASES-1:0] green;
  logic [NUM_PHASES-1:0] yellow;
  logic [NUM_PHASES-1:0] red;
  logic [PH_W-1:0]       cur_phase;
  logic [1:0]            state_o;

  modport master (
    output req, emerg, emerg_phase,
    input  green, yellow, red, cur_phase, state_o
  );

  modport slave (
    input  req, emerg, emerg_phase,
    output green, yellow, red, cur_phase, state_o
  );
endinterface

// File: rtl/multi_phase_traffic_ctrl.sv
// N-phase intersection controller: green/yellow/all-red cycle, round-robin service, emergency pre-emption.
// Lamps and status update one cycle after the deciding edge; no backpressure, inputs are levels.
module multi_phase_traffic_ctrl #(
  parameter int NUM_PHASES     = 4,
  parameter int MIN_GREEN      = 8,
  parameter int MAX_GREEN      = 24,
  parameter int YELLOW_CYCLES  = 3,
  parameter int ALL_RED_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  multi_phase_traffic_ctrl_if.slave bus
);
  localparam int PH_W  = $clog2(NUM_PHASES);
  localparam int TMR_W = $clog2(MAX_GREEN + 1);

  localparam logic [TMR_W-1:0]      TMR_SAT  = TMR_W'(MAX_GREEN);
  localparam logic [TMR_W-1:0]      MIN_LAST = TMR_W'(MIN_GREEN - 1);
  localparam logic [TMR_W-1:0]      MAX_LAST = TMR_W'(MAX_GREEN - 1);
  localparam logic [TMR_W-1:0]      YEL_LAST = TMR_W'(YELLOW_CYCLES - 1);
  localparam logic [TMR_W-1:0]      AR_LAST  = TMR_W'(ALL_RED_CYCLES - 1);
  localparam logic [NUM_PHASES-1:0] ONE      = NUM_PHASES'(1);

  typedef enum logic [1:0] {
    S_GREEN   = 2'd0,
    S_YELLOW  = 2'd1,
    S_ALL_RED = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [PH_W-1:0]       phase, phase_n;
  logic [PH_W-1:0]       next_phase, next_phase_n;
  logic [TMR_W-1:0]      timer, timer_n;
  logic [NUM_PHASES-1:0] other;
  logic                  rr_found;
  logic [PH_W-1:0]       rr_phase, rr_cand, inc_phase;
  logic                  emerg_ok;
  int                    rr_sum;

  // Round-robin pick: first pending request after the current phase, wrapping.
  always_comb begin
    other    = bus.req & ~(ONE << phase);
    rr_found = 1'b0;
    rr_phase = phase;
    rr_cand  = phase;
    rr_sum   = 0;
    for (int k = 1; k < NUM_PHASES; k++) begin
      rr_sum = int'(phase) + k;
      if (rr_sum >= NUM_PHASES) rr_sum = rr_sum - NUM_PHASES;
      rr_cand = PH_W'(rr_sum);
      if (!rr_found && other[rr_cand]) begin
        rr_found = 1'b1;
        rr_phase = rr_cand;
      end
    end
    inc_phase = (int'(phase) == NUM_PHASES - 1) ? '0 : phase + PH_W'(1);
  end

  always_comb begin
    emerg_ok     = bus.emerg && (int'(bus.emerg_phase) < NUM_PHASES);
    state_n      = state;
    phase_n      = phase;
    next_phase_n = next_phase;
    timer_n      = (timer == TMR_SAT) ? timer : timer + TMR_W'(1);
    case (state)
      S_GREEN: begin
        // Pre-emption to our own phase simply freezes the decision; timer keeps running.
        if (emerg_ok) begin
          if (bus.emerg_phase != phase) begin
            state_n      = S_YELLOW;
            next_phase_n = bus.emerg_phase;
          end
        end else if (timer >= MIN_LAST && rr_found) begin
          state_n      = S_YELLOW;
          next_phase_n = rr_phase;
        end else if (timer >= MAX_LAST) begin
          state_n      = S_YELLOW;
          next_phase_n = inc_phase;
        end
      end
      S_YELLOW: begin
        if (emerg_ok) next_phase_n = bus.emerg_phase;
        if (timer >= YEL_LAST) state_n = S_ALL_RED;
      end
      S_ALL_RED: begin
        if (emerg_ok) next_phase_n = bus.emerg_phase;
        if (timer >= AR_LAST) begin
          state_n = S_GREEN;
          phase_n = next_phase_n;
        end
      end
      default: state_n = S_GREEN;
    endcase
    if (state_n != state) timer_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_GREEN;
      phase      <= '0;
      next_phase <= PH_W'(1);
      timer      <= '0;
      bus.green  <= ONE;
      bus.yellow <= '0;
      bus.red    <= ~ONE;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      next_phase <= next_phase_n;
      timer      <= timer_n;
      bus.green  <= (state_n == S_GREEN)  ? (ONE << phase_n) : '0;
      bus.yellow <= (state_n == S_YELLOW) ? (ONE << phase_n) : '0;
      bus.red    <= (state_n == S_ALL_RED) ? '1 : ~(ONE << phase_n);
    end
  end

  assign bus.cur_phase = phase;
  assign bus.state_o   = state;
endmodule

// File: tb/tb_multi_phase_traffic_ctrl.sv
// Bench for multi_phase_traffic_ctrl: directed scenarios plus randomized traffic against a cycle-count model.
module tb_multi_phase_traffic_ctrl;
  localparam int N = 4, MIN = 8, MAX = 24, YEL = 3, AR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_phase_traffic_ctrl_if #(.NUM_PHASES(4)) bus ();
  multi_phase_traffic_ctrl_if #(.NUM_PHASES(2)) bus2 ();

  multi_phase_traffic_ctrl #(
    .NUM_PHASES(4), .MIN_GREEN(8), .MAX_GREEN(24), .YELLOW_CYCLES(3), .ALL_RED_CYCLES(2)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  multi_phase_traffic_ctrl #(
    .NUM_PHASES(2), .MIN_GREEN(2), .MAX_GREEN(4), .YELLOW_CYCLES(1), .ALL_RED_CYCLES(1)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int failures = 0;

  // Model: kind 0/1/2 = green/yellow/all-red, cnt = cycles shown so far in this interval.
  int m_kind, m_phase, m_next, m_cnt;

  typedef struct { int st; int ph; int len; } seg_t;
  seg_t segs[$];
  seg_t cur_seg;

  task automatic model_step(input logic r, input logic [3:0] rq, input logic e, input logic [1:0] ep);
    int ev, pick, bits, idx;
    bit leave;
    if (r) begin
      m_kind = 0; m_phase = 0; m_next = 1; m_cnt = 1;
      return;
    end
    ev    = e ? int'(ep) : -1;
    bits  = int'(rq);
    leave = 1'b0;
    pick  = -1;
    for (int s = 1; s < N; s++) begin
      idx = (m_phase + s) % N;
      if (pick < 0 && ((bits >> idx) & 1) == 1) pick = idx;
    end
    if (m_kind == 0) begin
      if (ev >= 0) begin
        if (ev != m_phase) begin leave = 1'b1; m_next = ev; end
      end else if (m_cnt >= MIN && pick >= 0) begin
        leave = 1'b1; m_next = pick;
      end else if (m_cnt >= MAX) begin
        leave = 1'b1; m_next = (m_phase + 1) % N;
      end
      if (leave) m_kind = 1;
    end else if (m_kind == 1) begin
      if (ev >= 0) m_next = ev;
      if (m_cnt >= YEL) begin leave = 1'b1; m_kind = 2; end
    end else begin
      if (ev >= 0) m_next = ev;
      if (m_cnt >= AR) begin leave = 1'b1; m_kind = 0; m_phase = m_next; end
    end
    m_cnt = leave ? 1 : m_cnt + 1;
  endtask

  function automatic logic [15:0] exp_vec();
    logic [3:0] one, g, y, r;
    one = 4'b0001;
    g = (m_kind == 0) ? (one << m_phase) : 4'b0000;
    y = (m_kind == 1) ? (one << m_phase) : 4'b0000;
    r = ~(g | y);
    return {g, y, r, 2'(m_phase), 2'(m_kind)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {bus.green, bus.yellow, bus.red, bus.cur_phase, bus.state_o};
  endfunction

  // One clock: sample the applied inputs, advance the model, and log observed lamp segments.
  task automatic tick();
    logic r, e;
    logic [3:0] rq;
    logic [1:0] ep;
    r = rst; rq = bus.req; e = bus.emerg; ep = bus.emerg_phase;
    @(posedge clk);
    #1;
    model_step(r, rq, e, ep);
    if (r) begin
      segs.delete();
      cur_seg.st = int'(bus.state_o); cur_seg.ph = int'(bus.cur_phase); cur_seg.len = 1;
    end else if (int'(bus.state_o) == cur_seg.st && int'(bus.cur_phase) == cur_seg.ph) begin
      cur_seg.len++;
    end else begin
      segs.push_back(cur_seg);
      cur_seg.st = int'(bus.state_o); cur_seg.ph = int'(bus.cur_phase); cur_seg.len = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0; bus.emerg = 1'b0; bus.emerg_phase = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 4'b1110; bus.emerg = 1'b1; bus.emerg_phase = 2'd2;
    bus2.req = 2'b10;
    tick(); tick();
    checks++; if (bus.green !== 4'b0001) begin failures++; $display("FAIL reset_green got=%b exp=0001", bus.green); end
    checks++; if (bus.yellow !== 4'b0000) begin failures++; $display("FAIL reset_yellow got=%b exp=0000", bus.yellow); end
    checks++; if (bus.red !== 4'b1110) begin failures++; $display("FAIL reset_red got=%b exp=1110", bus.red); end
    checks++; if (bus.state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state_o); end
    checks++; if (bus.cur_phase !== 2'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", bus.cur_phase); end
    checks++; if ({bus2.green, bus2.red} !== 4'b0110) begin failures++; $display("FAIL reset_dut2 got=%b exp=0110", {bus2.green, bus2.red}); end
    rst = 1'b0; bus.req = '0; bus.emerg = 1'b0; bus.emerg_phase = '0; bus2.req = '0;
  endtask

  task automatic test_rotation();
    int st, ph, len;
    do_reset();
    for (int c = 0; c < 118; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL rotation cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
    end
    for (int i = 0; i < 12; i++) begin
      st = i % 3; ph = i / 3; len = (st == 0) ? MAX : (st == 1) ? YEL : AR;
      checks++;
      if (i >= segs.size()) begin
        failures++; $display("FAIL rotation_seg%0d missing got=%0d segments exp>=12", i, segs.size());
      end else if (segs[i].st != st || segs[i].ph != ph || segs[i].len != len) begin
        failures++;
        $display("FAIL rotation_seg%0d got=st%0d/ph%0d/len%0d exp=st%0d/ph%0d/len%0d",
                 i, segs[i].st, segs[i].ph, segs[i].len, st, ph, len);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_st[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int exp_ph[9] = '{0, 0, 0, 2, 2, 2, 3, 3, 3};
    int exp_ln[9] = '{8, 3, 2, 8, 3, 2, 8, 3, 2};
    bit reached;
    do_reset();
    tick(); tick();
    bus.req = 4'b0100;
    reached = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL rr_to_p2 cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
      reached = (bus.state_o == 2'd0 && bus.cur_phase == 2'd2);
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL rr_wait_p2 got=timeout exp=phase2 green"); end
    bus.req = 4'b1010;
    for (int c = 0; c < 28; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL rr_p3_p1 cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= segs.size()) begin
        failures++; $display("FAIL rr_seg%0d missing got=%0d segments exp>=9", i, segs.size());
      end else if (segs[i].st != exp_st[i] || segs[i].ph != exp_ph[i] || segs[i].len != exp_ln[i]) begin
        failures++;
        $display("FAIL rr_seg%0d got=st%0d/ph%0d/len%0d exp=st%0d/ph%0d/len%0d",
                 i, segs[i].st, segs[i].ph, segs[i].len, exp_st[i], exp_ph[i], exp_ln[i]);
      end
    end
    checks++;
    if (cur_seg.st != 0 || cur_seg.ph != 1) begin
      failures++; $display("FAIL rr_final got=st%0d/ph%0d exp=st0/ph1", cur_seg.st, cur_seg.ph);
    end
    bus.req = '0;
  endtask

  task automatic test_emergency();
    int exp_st[3] = '{0, 1, 2};
    int exp_ln[3] = '{4, 3, 2};
    do_reset();
    tick(); tick(); tick();
    bus.emerg = 1'b1; bus.emerg_phase = 2'd1;
    for (int c = 0; c < 45; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL emerg cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= segs.size()) begin
        failures++; $display("FAIL emerg_seg%0d missing got=%0d segments exp>=3", i, segs.size());
      end else if (segs[i].st != exp_st[i] || segs[i].ph != 0 || segs[i].len != exp_ln[i]) begin
        failures++;
        $display("FAIL emerg_seg%0d got=st%0d/ph%0d/len%0d exp=st%0d/ph0/len%0d",
                 i, segs[i].st, segs[i].ph, segs[i].len, exp_st[i], exp_ln[i]);
      end
    end
    checks++;
    if (cur_seg.st != 0 || cur_seg.ph != 1 || cur_seg.len != 40) begin
      failures++; $display("FAIL emerg_hold got=st%0d/ph%0d/len%0d exp=st0/ph1/len40", cur_seg.st, cur_seg.ph, cur_seg.len);
    end
    bus.emerg = 1'b0;
    tick();
    checks++;
    if (bus.state_o !== 2'd1 || bus.cur_phase !== 2'd1) begin
      failures++; $display("FAIL emerg_release got=state%0d/ph%0d exp=state1/ph1", bus.state_o, bus.cur_phase);
    end
  endtask

  task automatic test_reset_mid();
    bit reached;
    do_reset();
    bus.req = 4'b0010;
    reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      tick();
      reached = (bus.state_o == 2'd1);
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL midrst_wait got=timeout exp=yellow"); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.req = '0;
    checks++; if (bus.green !== 4'b0001) begin failures++; $display("FAIL midrst_green got=%b exp=0001", bus.green); end
    checks++; if (bus.yellow !== 4'b0000) begin failures++; $display("FAIL midrst_yellow got=%b exp=0000", bus.yellow); end
    checks++; if (bus.red !== 4'b1110) begin failures++; $display("FAIL midrst_red got=%b exp=1110", bus.red); end
    checks++; if (bus.state_o !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", bus.state_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3) begin
        bus.emerg = ~bus.emerg;
        bus.emerg_phase = 2'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 999) < 3);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
    end
    rst = 1'b0; bus.emerg = 1'b0; bus.req = '0;
  endtask

  task automatic test_two_phase();
    logic [1:0] prev_g, prev_y, last_g, nonred;
    int glen;
    bus2.req = '0; bus2.emerg = 1'b0; bus2.emerg_phase = '0;
    do_reset();
    prev_g = bus2.green; prev_y = bus2.yellow; last_g = bus2.green; glen = 1;
    for (int c = 0; c < 1500; c++) begin
      bus2.req = 2'($urandom_range(0, 3));
      tick();
      nonred = bus2.green | bus2.yellow;
      checks++;
      if ($countones(nonred) > 1 || (bus2.green & bus2.yellow) != 0 || (nonred & bus2.red) != 0 || (nonred | bus2.red) != 2'b11) begin
        failures++; $display("FAIL two_lamps cyc=%0d got=g%b/y%b/r%b exp=one-hot, <=1 non-red", c, bus2.green, bus2.yellow, bus2.red);
      end
      if (bus2.green != 0 && bus2.green != prev_g) begin
        checks++;
        if ((prev_g | prev_y) != 0 || bus2.green == last_g) begin
          failures++; $display("FAIL two_change cyc=%0d got=prev_g%b/prev_y%b/new%b/last%b exp=all-red before new phase", c, prev_g, prev_y, bus2.green, last_g);
        end
        last_g = bus2.green; glen = 1;
      end else if (bus2.green != 0) begin
        glen++;
      end
      if (bus2.green == 0 && prev_g != 0) begin
        checks++;
        if (glen < 2 || glen > 4) begin failures++; $display("FAIL two_glen cyc=%0d got=%0d exp=2..4", c, glen); end
      end
      prev_g = bus2.green; prev_y = bus2.yellow;
    end
    bus2.req = '0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.emerg = 1'b0; bus.emerg_phase = '0;
    bus2.req = '0; bus2.emerg = 1'b0; bus2.emerg_phase = '0;
    test_reset();
    test_rotation();
    test_round_robin();
    test_emergency();
    test_reset_mid();
    test_random();
    test_two_phase();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
